// File: rtl/dual_boot_sequencer.sv
// Sequencer for the dual-image boot IP CSR: polls busy, selects the image, then triggers reconfig.
// Optional two-step request confirmation is enabled by defining DUAL_BOOT_SEQ_CONFIRM_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a switch request, req_ready high
// S_ARMED  | first request seen, waiting for a matching confirm (optional)
// S_POLL   | reading the busy flag until clear or the poll budget runs out
// S_WSEL   | writing {image, overwrite enable} to the config-select register
// S_SETTLE | idle gap between the select write and the trigger write
// S_WTRIG  | writing the reconfig trigger
// S_DONE   | trigger issued, device reconfigures; only reset leaves
// S_ERROR  | busy never cleared; sticky until reset
module dual_boot_sequencer #(
    parameter int unsigned ADDR_TRIG     = 0,
    parameter int unsigned ADDR_SEL      = 1,
    parameter int unsigned ADDR_BUSY     = 3,
    parameter int unsigned POLL_TIMEOUT  = 1000000,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_image,
    output logic        req_ready,
    output logic        seq_busy,
    output logic        seq_error,
    output logic [2:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES == 0) ? '0 : SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [23:0] POLL_LAST = 24'(POLL_TIMEOUT - 1);
    localparam logic [2:0]  A_TRIG = 3'(ADDR_TRIG);
    localparam logic [2:0]  A_SEL  = 3'(ADDR_SEL);
    localparam logic [2:0]  A_BUSY = 3'(ADDR_BUSY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_WSEL,
        S_SETTLE,
        S_WTRIG,
        S_DONE,
        S_ERROR
`ifdef DUAL_BOOT_SEQ_CONFIRM_EN
        , S_ARMED
`endif
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  image_q;
    logic [23:0]           poll_cnt;
    logic                  poll_gap;
    logic [SETTLE_W-1:0]   settle_cnt;
    logic                  poll_rd_done;
    logic                  busy_flag;
    logic                  unused_readdata;

`ifdef DUAL_BOOT_SEQ_CONFIRM_EN
    logic [25:0]           win_cnt;
`endif

    // Only bit 0 of the status word carries information.
    assign busy_flag       = avm_readdata[0];
    assign unused_readdata = ^avm_readdata[31:1];
    assign poll_rd_done    = (state == S_POLL) && !poll_gap && !avm_waitrequest;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        seq_busy      = 1'b1;
        seq_error     = 1'b0;
        avm_address   = 3'd0;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_writedata = 32'd0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                seq_busy  = 1'b0;
                if (req_valid) begin
`ifdef DUAL_BOOT_SEQ_CONFIRM_EN
                    state_next = S_ARMED;
`else
                    state_next = S_POLL;
`endif
                end
            end
`ifdef DUAL_BOOT_SEQ_CONFIRM_EN
            S_ARMED: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = (req_image == image_q) ? S_POLL : S_IDLE;
                end else if (win_cnt == '0) begin
                    state_next = S_IDLE;
                end
            end
`endif
            S_POLL: begin
                // poll_gap forces the one idle cycle between consecutive reads
                avm_read    = !poll_gap;
                avm_address = A_BUSY;
                if (poll_rd_done) begin
                    if (!busy_flag) begin
                        state_next = S_WSEL;
                    end else if (poll_cnt == POLL_LAST) begin
                        state_next = S_ERROR;
                    end
                end
            end
            S_WSEL: begin
                avm_write     = 1'b1;
                avm_address   = A_SEL;
                avm_writedata = {30'd0, image_q, 1'b1};
                if (!avm_waitrequest) begin
                    state_next = (SETTLE_CYCLES == 0) ? S_WTRIG : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_next = S_WTRIG;
                end
            end
            S_WTRIG: begin
                avm_write     = 1'b1;
                avm_address   = A_TRIG;
                avm_writedata = 32'd1;
                if (!avm_waitrequest) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_DONE;
            end
            S_ERROR: begin
                seq_busy  = 1'b0;
                seq_error = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            image_q    <= 1'b0;
            poll_cnt   <= '0;
            poll_gap   <= 1'b0;
            settle_cnt <= '0;
        end else begin
            poll_gap <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        image_q  <= req_image;
                        poll_cnt <= '0;
                    end
                end
`ifdef DUAL_BOOT_SEQ_CONFIRM_EN
                S_ARMED: begin
                    if (req_valid) begin
                        poll_cnt <= '0;
                    end
                end
`endif
                S_POLL: begin
                    if (poll_rd_done && busy_flag) begin
                        poll_cnt <= poll_cnt + 24'd1;
                        poll_gap <= 1'b1;
                    end
                end
                S_WSEL: begin
                    if (!avm_waitrequest) begin
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DUAL_BOOT_SEQ_CONFIRM_EN
    // Confirmation window: loaded on the first accept, expires at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt <= '0;
        end else if (state == S_IDLE && req_valid) begin
            win_cnt <= '1;
        end else if (state == S_ARMED && win_cnt != '0) begin
            win_cnt <= win_cnt - 26'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dual_boot_sequencer.sv
// Directed bench for dual_boot_sequencer with a small Avalon slave model and transfer log.
// Build with DUAL_BOOT_SEQ_CONFIRM_EN defined to exercise the double-request path.
module tb_dual_boot_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_image;
    logic        req_ready;
    logic        seq_busy;
    logic        seq_error;
    logic [2:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    int cyc = 0;
    int n_rd = 0;
    int n_wr = 0;
    int both_hi = 0;
    int rd_base = 0;
    int wr_base = 0;
    int busy_cfg = 0;
    logic busy_stuck = 1'b0;
    int checks = 0;
    int failures = 0;
    int acc;
    int dummy;

    logic [2:0]  wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    int          wr_cyc  [0:63];
    int          rd_cyc  [0:63];

    always #5 clk = ~clk;

    // Busy reads: stuck at 1, or 1 for the first busy_cfg reads of the current test.
    assign avm_readdata = {31'd0, busy_stuck || ((n_rd - rd_base) < busy_cfg)};

    dual_boot_sequencer #(
        .POLL_TIMEOUT (5),
        .SETTLE_CYCLES(16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_image      (req_image),
        .req_ready      (req_ready),
        .seq_busy       (seq_busy),
        .seq_error      (seq_error),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && avm_read && !avm_waitrequest) begin
            if (n_rd < 64) rd_cyc[n_rd] <= cyc;
            n_rd <= n_rd + 1;
        end
        if (!reset && avm_write && !avm_waitrequest) begin
            if (n_wr < 64) begin
                wr_addr[n_wr] <= avm_address;
                wr_data[n_wr] <= avm_writedata;
                wr_cyc[n_wr]  <= cyc;
            end
            n_wr <= n_wr + 1;
        end
        if (avm_read && avm_write) both_hi <= both_hi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rd_base = n_rd;
        wr_base = n_wr;
    endtask

    // Called at a negedge; acc is the index of the edge that accepts the request.
    task automatic pulse(input logic img, output int a);
        req_valid = 1'b1;
        req_image = img;
        a = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic issue(input logic img, output int a);
`ifdef DUAL_BOOT_SEQ_CONFIRM_EN
        pulse(img, a);
        @(negedge clk);
`endif
        pulse(img, a);
    endtask

    task automatic wait_writes(input int n, input string tag);
        int k;
        k = 0;
        while ((n_wr - wr_base) < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(n_wr - wr_base), 32'(n));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_image = 1'b0;
        avm_waitrequest = 1'b0;
        @(negedge clk);
        do_reset();

        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(seq_busy), 32'd0);
        chk("rst_error", 32'(seq_error), 32'd0);
        chk("rst_read", 32'(avm_read), 32'd0);
        chk("rst_write", 32'(avm_write), 32'd0);
        chk("rst_addr", 32'(avm_address), 32'd0);
        chk("rst_wdata", avm_writedata, 32'd0);

        // Basic switch to image 1, busy clear at once.
        issue(1'b1, acc);
        chk("t1_read_strobe", 32'(avm_read), 32'd1);
        chk("t1_read_addr", 32'(avm_address), 32'd3);
        chk("t1_ready_low", 32'(req_ready), 32'd0);
        repeat (10) @(negedge clk);
        chk("t1_settle_quiet", 32'({avm_read, avm_write}), 32'd0);
        chk("t1_settle_busy", 32'({seq_busy, req_ready}), 32'b10);
        wait_writes(2, "t1_write_count");
        chk("t1_read_count", 32'(n_rd - rd_base), 32'd1);
        chk("t1_read_edge", 32'(rd_cyc[rd_base]), 32'(acc + 1));
        chk("t1_sel_addr", 32'(wr_addr[wr_base]), 32'd1);
        chk("t1_sel_data", wr_data[wr_base], 32'h3);
        chk("t1_sel_edge", 32'(wr_cyc[wr_base]), 32'(acc + 2));
        chk("t1_trig_addr", 32'(wr_addr[wr_base + 1]), 32'd0);
        chk("t1_trig_data", wr_data[wr_base + 1], 32'h1);
        chk("t1_trig_gap", 32'(wr_cyc[wr_base + 1] - wr_cyc[wr_base]), 32'd17);
        chk("t1_done_busy", 32'({seq_busy, req_ready, seq_error}), 32'b100);
        pulse(1'b0, dummy);
        repeat (10) @(negedge clk);
        chk("t1_done_no_reads", 32'(n_rd - rd_base), 32'd1);
        chk("t1_done_no_writes", 32'(n_wr - wr_base), 32'd2);

        // Busy for three reads, then clear.
        do_reset();
        busy_cfg = 3;
        issue(1'b0, acc);
        wait_writes(2, "t2_write_count");
        chk("t2_read_count", 32'(n_rd - rd_base), 32'd4);
        chk("t2_read2_edge", 32'(rd_cyc[rd_base + 1]), 32'(acc + 3));
        chk("t2_read4_edge", 32'(rd_cyc[rd_base + 3]), 32'(acc + 7));
        chk("t2_sel_edge", 32'(wr_cyc[wr_base]), 32'(acc + 8));
        chk("t2_sel_data", wr_data[wr_base], 32'h1);
        chk("t2_trig_edge", 32'(wr_cyc[wr_base + 1]), 32'(acc + 25));
        chk("t2_error", 32'(seq_error), 32'd0);
        busy_cfg = 0;

        // Busy stuck: poll budget of 5 reads exhausted.
        do_reset();
        busy_stuck = 1'b1;
        issue(1'b1, acc);
        repeat (30) @(negedge clk);
        chk("t3_read_count", 32'(n_rd - rd_base), 32'd5);
        chk("t3_last_read_edge", 32'(rd_cyc[rd_base + 4]), 32'(acc + 9));
        chk("t3_no_writes", 32'(n_wr - wr_base), 32'd0);
        chk("t3_flags", 32'({seq_error, seq_busy, req_ready}), 32'b100);
        pulse(1'b1, dummy);
        repeat (5) @(negedge clk);
        chk("t3_error_sticky_reads", 32'(n_rd - rd_base), 32'd5);
        chk("t3_error_sticky", 32'(seq_error), 32'd1);
        busy_stuck = 1'b0;

        // Seven wait states on the select write, image 0.
        do_reset();
        issue(1'b0, acc);
        @(negedge clk);
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t4_hold_write", 32'(avm_write), 32'd1);
            chk("t4_hold_addr", 32'(avm_address), 32'd1);
            chk("t4_hold_data", avm_writedata, 32'h1);
            if (i == 7) begin
                chk("t4_no_early_done", 32'(n_wr - wr_base), 32'd0);
                avm_waitrequest = 1'b0;
            end
            @(negedge clk);
        end
        wait_writes(2, "t4_write_count");
        chk("t4_sel_edge", 32'(wr_cyc[wr_base]), 32'(acc + 9));
        chk("t4_trig_edge", 32'(wr_cyc[wr_base + 1]), 32'(acc + 26));
        chk("t4_trig_addr", 32'(wr_addr[wr_base + 1]), 32'd0);

        // Reset while the poll read is stalled.
        do_reset();
        issue(1'b1, acc);
        avm_waitrequest = 1'b1;
        @(negedge clk);
        chk("t5_stalled_read", 32'(avm_read), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_read_dropped", 32'(avm_read), 32'd0);
        chk("t5_idle", 32'({req_ready, seq_busy}), 32'b10);
        chk("t5_no_reads", 32'(n_rd - rd_base), 32'd0);
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        rd_base = n_rd;
        wr_base = n_wr;
        @(negedge clk);
        issue(1'b1, acc);
        wait_writes(2, "t5_rerun_writes");
        chk("t5_rerun_reads", 32'(n_rd - rd_base), 32'd1);
        chk("t5_rerun_sel_data", wr_data[wr_base], 32'h3);

`ifdef DUAL_BOOT_SEQ_CONFIRM_EN
        // Confirmed request 100 cycles apart.
        do_reset();
        pulse(1'b1, dummy);
        chk("c1_armed", 32'({req_ready, seq_busy, avm_read}), 32'b110);
        repeat (100) @(negedge clk);
        chk("c1_armed_quiet", 32'(n_rd - rd_base), 32'd0);
        pulse(1'b1, acc);
        wait_writes(2, "c1_write_count");
        chk("c1_sel_edge", 32'(wr_cyc[wr_base]), 32'(acc + 2));

        // Mismatched confirm returns to idle.
        do_reset();
        pulse(1'b1, dummy);
        @(negedge clk);
        pulse(1'b0, dummy);
        repeat (10) @(negedge clk);
        chk("c2_idle", 32'({req_ready, seq_busy}), 32'b10);
        chk("c2_no_reads", 32'(n_rd - rd_base), 32'd0);
        chk("c2_no_writes", 32'(n_wr - wr_base), 32'd0);
`endif

        chk("rw_exclusive", 32'(both_hi), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dual_boot_sequencer.md
Name: dual_boot_sequencer

Overview:
- Controller that sequences the dual-image boot IP's Avalon-MM CSR to switch the MAX10 to a selected configuration image.
- Accepts a one-shot image-switch request from user logic, e.g. a debounced key.
- Polls the IP busy flag, writes the config-select register, then issues the reconfig trigger.
- Sits beside the LED/PWM logic in the top level and is the only master of the dual-boot CSR.

Parameters:
- ADDR_TRIG, 0, CSR word address of reconfig trigger register (bit0 = trigger).
- ADDR_SEL, 1, CSR word address of config-select register (bit0 = overwrite enable, bit1 = image select).
- ADDR_BUSY, 3, CSR word address of status register (bit0 = IP busy).
- POLL_TIMEOUT, 1000000, maximum busy-poll reads before error; range 1..2^24-1.
- SETTLE_CYCLES, 16, idle clocks inserted between SEL write and TRIG write; 0 allowed.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  switch request
- req_image  in  1  target image (0 = CFM0/image0, 1 = image1)
- req_ready  out  1  high only in IDLE
- seq_busy  out  1  high in any state other than IDLE and ERROR
- seq_error  out  1  sticky poll-timeout flag
- avm_address  out  3  CSR address
- avm_read  out  1  read strobe
- avm_write  out  1  write strobe
- avm_writedata  out  32  write data
- avm_readdata  in  32  read data
- avm_waitrequest  in  1  slave stall

Behaviour:
- Single clock domain. Reset is synchronous and active-high; all state is updated on the rising edge of clk.
- Reset values: FSM = IDLE, req_ready = 1, seq_busy = 0, seq_error = 0, avm_read = 0, avm_write = 0, avm_address = 0, avm_writedata = 0, counters = 0.
- Handshake: a request is accepted when req_valid & req_ready. req_image is latched on that edge. req_valid while not ready is ignored, not queued.
- Avalon rules:
  - Address, strobe and data are held stable while avm_waitrequest = 1.
  - A transfer completes on the edge where the strobe is high and waitrequest = 0.
  - Reads are zero-latency: avm_readdata is sampled on the completing edge.
  - Read and write are never high together.
- IDLE: on accept -> POLL, with poll counter cleared.
- POLL: drive avm_read = 1 at ADDR_BUSY.
  - On completion with readdata[0] = 0 -> WSEL.
  - On completion with readdata[0] = 1: increment the poll counter. If the counter reaches POLL_TIMEOUT -> ERROR; otherwise stay in POLL. The strobe drops for exactly one cycle between reads.
- WSEL: drive avm_write = 1 at ADDR_SEL with writedata = {30'b0, image, 1'b1}.
  - On completion -> SETTLE, or -> WTRIG if SETTLE_CYCLES = 0.
- SETTLE: count SETTLE_CYCLES clocks with no bus activity -> WTRIG.
- WTRIG: drive avm_write = 1 at ADDR_TRIG with writedata = 32'h1.
  - On completion -> DONE.
- DONE: terminal state. seq_busy stays 1 and no further bus activity occurs. The device reconfigures externally; only reset leaves DONE.
- ERROR: seq_error = 1, seq_busy = 0, req_ready = 0. Only reset clears it.
- Latency with no wait states and the busy flag clear on the first read: accept at edge 0; POLL read completes at edge 1; WSEL completes at edge 2; SETTLE occupies edges 3..2+SETTLE_CYCLES; WTRIG completes at the next edge.
- Reset asserted mid-transfer: strobes drop on the next edge even if waitrequest = 1, and the FSM returns to IDLE.

Optional Feature:
- Macro DUAL_BOOT_SEQ_CONFIRM_EN.
- Defined: a request must be issued twice.
  - The first accept moves the FSM to ARMED (req_ready = 1, seq_busy = 1) and starts a 2^26-cycle window.
  - A second accept with the same req_image inside the window -> POLL.
  - A different image, or the window expiring, -> IDLE.
- Undefined: the first accept goes directly to POLL; the ARMED state and its window counter are not synthesized.

Test Plan:
- Reset, then req_valid = 1, req_image = 1, busy read = 0, no waitstates, SETTLE_CYCLES = 16. Required bus sequence: read addr 3; write addr 1 data 0x3; write addr 0 data 0x1 exactly 17 edges after the SEL write completes. seq_busy = 1, req_ready = 0 throughout.
- Busy reads return 1 three times, then 0. Required: exactly 4 reads with one idle cycle between each, then the normal SEL/TRIG writes; seq_error = 0.
- POLL_TIMEOUT = 5, busy stuck at 1. Required: exactly 5 reads, then seq_error = 1, seq_busy = 0, and no writes occur.
- avm_waitrequest held high 7 cycles during the WSEL write with req_image = 0. Required: address 1 and data 0x1 stay stable for all 8 cycles and WTRIG begins only afterwards.
- Reset pulsed while the POLL read is stalled. Required: avm_read = 0 on the next edge, FSM in IDLE, req_ready = 1; a new request then runs normally.
- With DUAL_BOOT_SEQ_CONFIRM_EN: two requests for image 1 spaced 100 cycles apart start the sequence; requests for image 1 then image 0 return to IDLE with no bus traffic.
